// File: rtl/axi_lite_slave_regs_if.sv
// AXI4-Lite bus bundle between a master and the register slave.
// The master modport drives requests and the slave modport drives responses.
interface axi_lite_slave_regs_if #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   AWADDR;
    logic [2:0]              AWPROT;
    logic                    AWVALID;
    logic                    AWREADY;
    logic [DATA_WIDTH-1:0]   WDATA;
    logic [DATA_WIDTH/8-1:0] WSTRB;
    logic                    WVALID;
    logic                    WREADY;
    logic [1:0]              BRESP;
    logic                    BVALID;
    logic                    BREADY;
    logic [ADDR_WIDTH-1:0]   ARADDR;
    logic [2:0]              ARPROT;
    logic                    ARVALID;
    logic                    ARREADY;
    logic [DATA_WIDTH-1:0]   RDATA;
    logic [1:0]              RRESP;
    logic                    RVALID;
    logic                    RREADY;

    modport master (
        output AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
               ARADDR, ARPROT, ARVALID, RREADY,
        input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );

    modport slave (
        input  AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
               ARADDR, ARPROT, ARVALID, RREADY,
        output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );
endinterface

// File: rtl/axi_lite_slave_regs.sv
// AXI4-Lite slave with seven read/write registers and a read-only ID register.
// AW and W are captured independently and committed once both are held.
module axi_lite_slave_regs #(
    parameter int          C_S_AXI_DATA_WIDTH = 32,
    parameter int          C_S_AXI_ADDR_WIDTH = 6,
    parameter logic [31:0] C_ID_VALUE         = 32'hA11E_0001
) (
    input logic                  ACLK,
    input logic                  ARESETN,
    axi_lite_slave_regs_if.slave s_axi
);

    localparam int         NUM_LANES = C_S_AXI_DATA_WIDTH / 8;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic [C_S_AXI_DATA_WIDTH-1:0] regs [0:6];

    logic                          aw_held;
    logic [C_S_AXI_ADDR_WIDTH-1:0] aw_addr_q;
    logic                          w_held;
    logic [C_S_AXI_DATA_WIDTH-1:0] w_data_q;
    logic [NUM_LANES-1:0]          w_strb_q;
    logic                          bvalid_q;
    logic [1:0]                    bresp_q;

    logic                          rvalid_q;
    logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q;
    logic [1:0]                    rresp_q;

    logic       aw_ready;
    logic       w_ready;
    logic       ar_ready;
    logic [2:0] wr_index;
    logic       wr_allowed;
    logic [2:0] rd_index;
    logic       rd_out_of_range;
    logic       unused_bits;

    // Ready signals depend only on registered state so VALID never loops back into READY.
    assign aw_ready = !aw_held && !bvalid_q;
    assign w_ready  = !w_held && !bvalid_q;
    assign ar_ready = !rvalid_q;

    assign wr_index        = aw_addr_q[4:2];
    assign wr_allowed      = !(|aw_addr_q[C_S_AXI_ADDR_WIDTH-1:5]) && (wr_index != 3'd7);
    assign rd_index        = s_axi.ARADDR[4:2];
    assign rd_out_of_range = |s_axi.ARADDR[C_S_AXI_ADDR_WIDTH-1:5];

    assign s_axi.AWREADY = aw_ready;
    assign s_axi.WREADY  = w_ready;
    assign s_axi.BVALID  = bvalid_q;
    assign s_axi.BRESP   = bresp_q;
    assign s_axi.ARREADY = ar_ready;
    assign s_axi.RVALID  = rvalid_q;
    assign s_axi.RDATA   = rdata_q;
    assign s_axi.RRESP   = rresp_q;

    assign unused_bits = ^{s_axi.AWPROT, s_axi.ARPROT, s_axi.ARADDR[1:0], aw_addr_q[1:0]};

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            for (int i = 0; i < 7; i++) begin
                regs[i] <= '0;
            end
            aw_held   <= 1'b0;
            aw_addr_q <= '0;
            w_held    <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
        end else begin
            if (aw_ready && s_axi.AWVALID) begin
                aw_held   <= 1'b1;
                aw_addr_q <= s_axi.AWADDR;
            end
            if (w_ready && s_axi.WVALID) begin
                w_held   <= 1'b1;
                w_data_q <= s_axi.WDATA;
                w_strb_q <= s_axi.WSTRB;
            end
            // Both halves held: commit one edge after the later handshake.
            if (aw_held && w_held) begin
                aw_held  <= 1'b0;
                w_held   <= 1'b0;
                bvalid_q <= 1'b1;
                bresp_q  <= wr_allowed ? RESP_OKAY : RESP_SLVERR;
                if (wr_allowed) begin
                    for (int b = 0; b < NUM_LANES; b++) begin
                        if (w_strb_q[b]) begin
                            regs[wr_index][8*b +: 8] <= w_data_q[8*b +: 8];
                        end
                    end
                end
            end else if (bvalid_q && s_axi.BREADY) begin
                bvalid_q <= 1'b0;
            end
        end
    end

    // Reads sample the register array before any same-edge write lands.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
        end else if (ar_ready && s_axi.ARVALID) begin
            rvalid_q <= 1'b1;
            if (rd_out_of_range) begin
                rdata_q <= '0;
                rresp_q <= RESP_SLVERR;
            end else if (rd_index == 3'd7) begin
                rdata_q <= C_ID_VALUE;
                rresp_q <= RESP_OKAY;
            end else begin
                rdata_q <= regs[rd_index];
                rresp_q <= RESP_OKAY;
            end
        end else if (rvalid_q && s_axi.RREADY) begin
            rvalid_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axi_lite_slave_regs.sv
// Self-checking bench for axi_lite_slave_regs: directed scenarios plus random
// traffic compared against a register-map model of the slave.
module tb_axi_lite_slave_regs;

    localparam logic [31:0] ID_VALUE = 32'hA11E_0001;

    logic aclk;
    logic aresetn;
    int   assertions;
    int   failures;

    logic [31:0] model_regs [0:6];

    axi_lite_slave_regs_if #(.ADDR_WIDTH(6), .DATA_WIDTH(32)) bus ();

    axi_lite_slave_regs #(
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(6),
        .C_ID_VALUE(ID_VALUE)
    ) dut (
        .ACLK(aclk),
        .ARESETN(aresetn),
        .s_axi(bus.slave)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Register-map model: bits [5] select out of range, bits [4:2] pick the register.
    function automatic logic [31:0] model_rdata(input logic [5:0] addr);
        if (addr[5]) return 32'h0;
        if (addr[4:2] == 3'd7) return ID_VALUE;
        return model_regs[addr[4:2]];
    endfunction

    function automatic logic [1:0] model_rresp(input logic [5:0] addr);
        return addr[5] ? 2'b10 : 2'b00;
    endfunction

    function automatic logic [1:0] model_write(input logic [5:0] addr, input logic [31:0] data,
                                               input logic [3:0] strb);
        logic [31:0] mask;
        if (addr[5] || addr[4:2] == 3'd7) return 2'b10;
        mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
        model_regs[addr[4:2]] = (model_regs[addr[4:2]] & ~mask) | (data & mask);
        return 2'b00;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 7; i++) model_regs[i] = 32'h0;
    endfunction

    task automatic tick;
        @(posedge aclk);
        #1;
    endtask

    task automatic do_write(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_delay, input int w_delay, input int bready_delay,
                            input string name);
        bit aw_done;
        bit w_done;
        bit hs_aw;
        bit hs_w;
        int cyc;
        logic [1:0] exp_resp;
        aw_done = 0;
        w_done = 0;
        cyc = 0;
        bus.AWADDR = addr;
        bus.AWPROT = 3'($urandom);
        bus.WDATA = data;
        bus.WSTRB = strb;
        bus.BREADY = 1'b0;
        while (!(aw_done && w_done) && cyc < 64) begin
            bus.AWVALID = !aw_done && (cyc >= aw_delay);
            bus.WVALID = !w_done && (cyc >= w_delay);
            hs_aw = bus.AWVALID && bus.AWREADY;
            hs_w = bus.WVALID && bus.WREADY;
            if (aw_done) begin
                assertions++;
                if (bus.AWREADY !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL %s awready_while_held: got %b expected 0", name, bus.AWREADY);
                end
            end
            if (w_done) begin
                assertions++;
                if (bus.WREADY !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL %s wready_while_held: got %b expected 0", name, bus.WREADY);
                end
            end
            tick();
            if (hs_aw) aw_done = 1;
            if (hs_w) w_done = 1;
            cyc++;
        end
        bus.AWVALID = 1'b0;
        bus.WVALID = 1'b0;
        assertions++;
        if (!(aw_done && w_done)) begin
            failures++;
            $display("[TB] FAIL %s handshake_timeout: got aw=%b w=%b expected both 1", name, aw_done, w_done);
            return;
        end
        assertions++;
        if (bus.BVALID !== 1'b0) begin
            failures++;
            $display("[TB] FAIL %s bvalid_before_commit: got %b expected 0", name, bus.BVALID);
        end
        tick();
        exp_resp = model_write(addr, data, strb);
        assertions++;
        if (bus.BVALID !== 1'b1 || bus.BRESP !== exp_resp) begin
            failures++;
            $display("[TB] FAIL %s bresp: got valid=%b resp=%b expected valid=1 resp=%b",
                     name, bus.BVALID, bus.BRESP, exp_resp);
        end
        repeat (bready_delay) begin
            tick();
            assertions++;
            if (bus.BVALID !== 1'b1 || bus.BRESP !== exp_resp || bus.AWREADY !== 1'b0 || bus.WREADY !== 1'b0) begin
                failures++;
                $display("[TB] FAIL %s b_stall: got valid=%b resp=%b awready=%b wready=%b expected 1 %b 0 0",
                         name, bus.BVALID, bus.BRESP, bus.AWREADY, bus.WREADY, exp_resp);
            end
        end
        bus.BREADY = 1'b1;
        tick();
        bus.BREADY = 1'b0;
        assertions++;
        if (bus.BVALID !== 1'b0 || bus.AWREADY !== 1'b1 || bus.WREADY !== 1'b1) begin
            failures++;
            $display("[TB] FAIL %s b_done: got valid=%b awready=%b wready=%b expected 0 1 1",
                     name, bus.BVALID, bus.AWREADY, bus.WREADY);
        end
    endtask

    task automatic do_read(input logic [5:0] addr, input int ar_delay, input int rready_delay,
                           input string name);
        logic [31:0] exp_data;
        logic [1:0] exp_resp;
        bus.RREADY = 1'b0;
        repeat (ar_delay) tick();
        bus.ARADDR = addr;
        bus.ARPROT = 3'($urandom);
        bus.ARVALID = 1'b1;
        assertions++;
        if (bus.ARREADY !== 1'b1) begin
            failures++;
            $display("[TB] FAIL %s arready_idle: got %b expected 1", name, bus.ARREADY);
        end
        exp_data = model_rdata(addr);
        exp_resp = model_rresp(addr);
        tick();
        bus.ARVALID = 1'b0;
        assertions++;
        if (bus.RVALID !== 1'b1 || bus.RDATA !== exp_data || bus.RRESP !== exp_resp) begin
            failures++;
            $display("[TB] FAIL %s rdata: got valid=%b data=%h resp=%b expected valid=1 data=%h resp=%b",
                     name, bus.RVALID, bus.RDATA, bus.RRESP, exp_data, exp_resp);
        end
        repeat (rready_delay) begin
            tick();
            assertions++;
            if (bus.RVALID !== 1'b1 || bus.RDATA !== exp_data || bus.RRESP !== exp_resp || bus.ARREADY !== 1'b0) begin
                failures++;
                $display("[TB] FAIL %s r_stall: got valid=%b data=%h resp=%b arready=%b expected 1 %h %b 0",
                         name, bus.RVALID, bus.RDATA, bus.RRESP, bus.ARREADY, exp_data, exp_resp);
            end
        end
        bus.RREADY = 1'b1;
        tick();
        bus.RREADY = 1'b0;
        assertions++;
        if (bus.RVALID !== 1'b0 || bus.ARREADY !== 1'b1) begin
            failures++;
            $display("[TB] FAIL %s r_done: got valid=%b arready=%b expected 0 1", name, bus.RVALID, bus.ARREADY);
        end
    endtask

    task automatic test_reset;
        aresetn = 1'b0;
        repeat (3) tick();
        assertions++;
        if (bus.BVALID !== 1'b0 || bus.RVALID !== 1'b0 || bus.BRESP !== 2'b00 ||
            bus.RRESP !== 2'b00 || bus.RDATA !== 32'h0) begin
            failures++;
            $display("[TB] FAIL reset_outputs: got bvalid=%b rvalid=%b bresp=%b rresp=%b rdata=%h expected all 0",
                     bus.BVALID, bus.RVALID, bus.BRESP, bus.RRESP, bus.RDATA);
        end
        aresetn = 1'b1;
        model_reset();
        tick();
        assertions++;
        if (bus.AWREADY !== 1'b1 || bus.WREADY !== 1'b1 || bus.ARREADY !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_ready: got aw=%b w=%b ar=%b expected 1 1 1",
                     bus.AWREADY, bus.WREADY, bus.ARREADY);
        end
        for (int i = 0; i < 8; i++) do_read(6'(i * 4), 0, 0, "reset_read");
    endtask

    task automatic test_basic;
        do_write(6'h04, 32'hDEADBEEF, 4'b1111, 0, 0, 0, "basic_write");
        do_read(6'h04, 0, 0, "basic_read");
    endtask

    task automatic test_w_first;
        do_write(6'h08, 32'h12345678, 4'b0011, 3, 0, 0, "w_first_write");
        do_read(6'h08, 0, 0, "w_first_read");
    endtask

    task automatic test_slverr;
        do_write(6'h1C, 32'hFFFF_FFFF, 4'b1111, 0, 1, 0, "id_write");
        do_read(6'h1C, 0, 0, "id_read");
        do_read(6'h20, 0, 0, "oor_read");
        do_write(6'h24, 32'h5555_AAAA, 4'b1111, 1, 0, 0, "oor_write");
        do_read(6'h04, 0, 0, "oor_alias_read");
        do_write(6'h0C, 32'hCAFE_F00D, 4'b0000, 0, 0, 0, "zero_strb_write");
        do_read(6'h0C, 0, 0, "zero_strb_read");
    endtask

    task automatic test_bready_stall;
        do_write(6'h10, 32'h0BAD_CAFE, 4'b1111, 0, 0, 5, "bstall_write");
        do_write(6'h14, 32'h7777_1111, 4'b1010, 0, 2, 0, "bstall_second");
        do_read(6'h10, 0, 0, "bstall_read0");
        do_read(6'h14, 0, 0, "bstall_read1");
    endtask

    task automatic test_rready_stall;
        do_write(6'h00, 32'h1111_2222, 4'b1111, 0, 0, 0, "rstall_init");
        fork
            do_read(6'h00, 0, 4, "rstall_read");
            do_write(6'h00, 32'h3333_4444, 4'b1111, 1, 1, 0, "rstall_rewrite");
        join
        do_read(6'h00, 0, 0, "rstall_after");
    endtask

    task automatic test_same_edge;
        fork
            do_write(6'h18, 32'hA5A5_5A5A, 4'b1111, 0, 0, 0, "same_edge_write");
            do_read(6'h18, 1, 0, "same_edge_read");
        join
        do_read(6'h18, 0, 0, "same_edge_after");
    endtask

    task automatic test_random;
        for (int n = 0; n < 40; n++) begin
            logic [5:0] waddr;
            logic [5:0] raddr;
            waddr = 6'($urandom_range(0, 63));
            raddr = 6'($urandom_range(0, 63));
            case ($urandom_range(0, 2))
                0: do_write(waddr, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                            $urandom_range(0, 3), $urandom_range(0, 2), "rand_write");
                1: do_read(raddr, $urandom_range(0, 1), $urandom_range(0, 2), "rand_read");
                default: fork
                    do_write(waddr, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 2),
                             $urandom_range(0, 2), $urandom_range(0, 2), "rand_par_write");
                    do_read(raddr, $urandom_range(0, 2), $urandom_range(0, 2), "rand_par_read");
                join
            endcase
        end
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 8; i++) do_read(6'(i * 4), 0, 0, "b2b_read");
    endtask

    task automatic test_reset_mid;
        for (int i = 0; i < 7; i++) do_write(6'(i * 4), 32'hF0F0_0000 | 32'(i), 4'b1111, 0, 0, 0, "mid_fill");
        bus.AWADDR = 6'h08;
        bus.AWVALID = 1'b1;
        tick();
        bus.AWVALID = 1'b0;
        assertions++;
        if (bus.AWREADY !== 1'b0) begin
            failures++;
            $display("[TB] FAIL mid_aw_captured: got awready=%b expected 0", bus.AWREADY);
        end
        aresetn = 1'b0;
        #2;
        assertions++;
        if (bus.AWREADY !== 1'b1 || bus.WREADY !== 1'b1) begin
            failures++;
            $display("[TB] FAIL mid_async_clear: got aw=%b w=%b expected 1 1", bus.AWREADY, bus.WREADY);
        end
        aresetn = 1'b1;
        model_reset();
        tick();
        bus.WDATA = 32'hFEED_BEEF;
        bus.WSTRB = 4'b1111;
        bus.WVALID = 1'b1;
        tick();
        bus.WVALID = 1'b0;
        repeat (4) begin
            tick();
            assertions++;
            if (bus.BVALID !== 1'b0) begin
                failures++;
                $display("[TB] FAIL mid_w_alone: got bvalid=%b expected 0", bus.BVALID);
            end
        end
        aresetn = 1'b0;
        tick();
        aresetn = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) do_read(6'(i * 4), 0, 0, "mid_read");
    endtask

    initial begin
        assertions = 0;
        failures = 0;
        aresetn = 1'b0;
        bus.AWADDR = '0;
        bus.AWPROT = '0;
        bus.AWVALID = 1'b0;
        bus.WDATA = '0;
        bus.WSTRB = '0;
        bus.WVALID = 1'b0;
        bus.BREADY = 1'b0;
        bus.ARADDR = '0;
        bus.ARPROT = '0;
        bus.ARVALID = 1'b0;
        bus.RREADY = 1'b0;
        model_reset();
        $display("[TB] starting axi_lite_slave_regs bench");
        test_reset();
        test_basic();
        test_w_first();
        test_slverr();
        test_bready_stall();
        test_rready_stall();
        test_same_edge();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
